// File: rtl/channel_readout_arbiter.sv
// Per-channel ADC capture into small local FIFOs, drained round-robin into a single
// valid/ready stream of {chan_id, timestamp, adc} words with per-channel overflow tracking.
module channel_readout_arbiter #(
  parameter int NUMCHANNELS      = 64,
  parameter int ADCBITS          = 10,
  parameter int LOCAL_FIFO_DEPTH = 4,
  parameter int TS_BITS          = 24,
  parameter int CHAN_W           = $clog2(NUMCHANNELS),
  parameter int DROP_CNT_W       = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUMCHANNELS-1:0]             done,
  input  logic [NUMCHANNELS*ADCBITS-1:0]     dout,
  input  logic [TS_BITS-1:0]                 timestamp,
  input  logic [NUMCHANNELS-1:0]             channel_mask,
  input  logic                               clear_overflow,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHAN_W+TS_BITS+ADCBITS-1:0]  out_data,
  output logic [NUMCHANNELS-1:0]             fifo_full,
  output logic [NUMCHANNELS-1:0]             overflow,
  output logic [DROP_CNT_W-1:0]              drop_count
);

  localparam int ENTRY_W = TS_BITS + ADCBITS;
  localparam int PTR_W   = $clog2(LOCAL_FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int POP_W   = $clog2(NUMCHANNELS + 1);
  localparam int SUM_W   = ((DROP_CNT_W > POP_W) ? DROP_CNT_W : POP_W) + 1;

  logic [ENTRY_W-1:0]     mem [NUMCHANNELS][LOCAL_FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr [NUMCHANNELS];
  logic [PTR_W-1:0]       rd_ptr [NUMCHANNELS];
  logic [CNT_W-1:0]       count [NUMCHANNELS];
  logic [CNT_W-1:0]       cnt_nxt [NUMCHANNELS];
  logic [NUMCHANNELS-1:0] done_d, push, pop, drop, wr, empty_v, full_v;
  logic [CHAN_W-1:0]      rr_ptr, grant, rr_nxt;
  logic                   any_ne, load;
  logic [POP_W-1:0]       drop_num;
  logic [SUM_W-1:0]       drop_sum;
  logic [DROP_CNT_W-1:0]  drop_sat;

  // Output handshake: a word transfers on any edge where out_valid && out_ready;
  // the output register may reload only when empty or being accepted.
  assign load = !out_valid || out_ready;
  assign push = done & ~done_d & ~channel_mask;

  always_comb begin
    for (int i = 0; i < NUMCHANNELS; i++) begin
      empty_v[i] = (count[i] == '0);
      full_v[i]  = (count[i] == CNT_W'(LOCAL_FIFO_DEPTH));
    end
  end

  // First non-empty channel at or after rr_ptr, wrapping at NUMCHANNELS-1.
  always_comb begin
    logic [CHAN_W-1:0] idx;
    any_ne = 1'b0;
    grant  = '0;
    for (int k = 0; k < NUMCHANNELS; k++) begin
      idx = CHAN_W'((int'(rr_ptr) + k) % NUMCHANNELS);
      if (!any_ne && !empty_v[idx]) begin
        any_ne = 1'b1;
        grant  = idx;
      end
    end
  end

  assign rr_nxt = (grant == CHAN_W'(NUMCHANNELS - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUMCHANNELS; i++) begin
      pop[i]  = load && any_ne && (grant == CHAN_W'(i));
      // A full FIFO still accepts a push when its head leaves in the same cycle.
      drop[i] = push[i] && full_v[i] && !pop[i];
      wr[i]   = push[i] && !drop[i];
      case ({wr[i], pop[i]})
        2'b10:   cnt_nxt[i] = count[i] + 1'b1;
        2'b01:   cnt_nxt[i] = count[i] - 1'b1;
        default: cnt_nxt[i] = count[i];
      endcase
      drop_num = drop_num + POP_W'(drop[i]);
    end
  end

  always_comb begin
    drop_sum = SUM_W'(drop_count) + SUM_W'(drop_num);
    if (drop_sum > SUM_W'({DROP_CNT_W{1'b1}})) drop_sat = {DROP_CNT_W{1'b1}};
    else                                        drop_sat = drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUMCHANNELS; i++) begin
      if (wr[i]) mem[i][wr_ptr[i]] <= {timestamp, dout[i*ADCBITS +: ADCBITS]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_d     <= '0;
      fifo_full  <= '0;
      overflow   <= '0;
      drop_count <= '0;
      rr_ptr     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      for (int i = 0; i < NUMCHANNELS; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      done_d <= done;
      for (int i = 0; i < NUMCHANNELS; i++) begin
        count[i]     <= cnt_nxt[i];
        fifo_full[i] <= (cnt_nxt[i] == CNT_W'(LOCAL_FIFO_DEPTH));
        if (wr[i])  wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
      end
      if (clear_overflow) begin
        overflow   <= '0;
        drop_count <= '0;
      end else begin
        overflow   <= overflow | drop;
        drop_count <= drop_sat;
      end
      if (load) begin
        if (any_ne) begin
          out_valid <= 1'b1;
          out_data  <= {grant, mem[grant][rd_ptr[grant]]};
          rr_ptr    <= rr_nxt;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Directed bench for channel_readout_arbiter: expected words queued at stimulus time,
// popped and compared by a monitor on every accepted output word.
module tb_channel_readout_arbiter;
  localparam int N  = 64;
  localparam int AB = 10;
  localparam int TW = 24;
  localparam int CW = 6;
  localparam int DW = 2;
  localparam int OW = CW + TW + AB;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    done = '0;
  logic [N*AB-1:0] dout = '0;
  logic [TW-1:0]   timestamp = '0;
  logic [N-1:0]    channel_mask = '0;
  logic            clear_overflow = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OW-1:0]   out_data;
  logic [N-1:0]    fifo_full, overflow;
  logic [DW-1:0]   drop_count;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_w;
  int total = 0;
  int bad = 0;

  channel_readout_arbiter #(
    .NUMCHANNELS(N), .ADCBITS(AB), .LOCAL_FIFO_DEPTH(4), .TS_BITS(TW), .DROP_CNT_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .done(done), .dout(dout), .timestamp(timestamp),
    .channel_mask(channel_mask), .clear_overflow(clear_overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fifo_full(fifo_full),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %h, required no word", out_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (out_data !== exp_w) begin
          bad++;
          $display("FAIL out_word: got %h, required %h", out_data, exp_w);
        end
      end
    end
  end

  function automatic logic [OW-1:0] mk(input int ch, input logic [TW-1:0] ts,
                                       input logic [AB-1:0] adc);
    return {CW'(ch), ts, adc};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input int ch, input logic [AB-1:0] adc, input logic [TW-1:0] ts,
                       input bit expect_push);
    dout[ch*AB +: AB] = adc;
    timestamp = ts;
    done[ch] = 1'b1;
    if (expect_push) exp_q.push_back(mk(ch, ts, adc));
    tick();
    done[ch] = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic clear_pulse();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_full", 64'(fifo_full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);

    // T1: single capture, minimum latency
    out_ready = 1'b1;
    dout[5*AB +: AB] = 10'h155;
    timestamp = 24'h000100;
    done[5] = 1'b1;
    exp_q.push_back(mk(5, 24'h000100, 10'h155));
    tick();
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    done[5] = 1'b0;
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'({6'd5, 24'h000100, 10'h155}));
    tick();
    chk("t1_idle", 64'(out_valid), 64'd0);
    wait_drain("t1_drain");

    // T2: simultaneous hits drain in order, then rr wraps back to ch0
    do_reset();
    out_ready = 1'b1;
    timestamp = 24'h000200;
    dout[0*AB +: AB] = 10'h011;
    dout[3*AB +: AB] = 10'h033;
    dout[63*AB +: AB] = 10'h3f3;
    done[0] = 1'b1; done[3] = 1'b1; done[63] = 1'b1;
    exp_q.push_back(mk(0, 24'h000200, 10'h011));
    exp_q.push_back(mk(3, 24'h000200, 10'h033));
    exp_q.push_back(mk(63, 24'h000200, 10'h3f3));
    tick();
    done = '0;
    tick();
    dout[0*AB +: AB] = 10'h2aa;
    timestamp = 24'h000300;
    done[0] = 1'b1;
    exp_q.push_back(mk(0, 24'h000300, 10'h2aa));
    tick();
    done[0] = 1'b0;
    wait_drain("t2_drain");

    // T3: stalled output, fill to full, overflow on the next hit, then clear
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 6; p++) begin
      pulse(7, AB'(10'h040 + p), TW'(24'h001000 + p), p < 5);
      if (p == 4) begin
        chk("t3_full", 64'(fifo_full[7]), 64'd1);
        chk("t3_no_ovf_yet", 64'(overflow[7]), 64'd0);
      end
    end
    chk("t3_ovf", 64'(overflow), 64'd1 << 7);
    chk("t3_drop", 64'(drop_count), 64'd1);
    chk("t3_full_kept", 64'(fifo_full[7]), 64'd1);
    chk("t3_stall_data", 64'(out_data), 64'(mk(7, 24'h001000, 10'h040)));
    chk("t3_stall_valid", 64'(out_valid), 64'd1);
    clear_pulse();
    chk("t3_clr_ovf", 64'(overflow), 64'd0);
    chk("t3_clr_drop", 64'(drop_count), 64'd0);
    out_ready = 1'b1;
    wait_drain("t3_drain");

    // T4: push into a full FIFO while its head is popped
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 5; p++) pulse(2, AB'(10'h100 + p), TW'(24'h002000 + p), 1'b1);
    chk("t4_full_before", 64'(fifo_full[2]), 64'd1);
    dout[2*AB +: AB] = 10'h1ff;
    timestamp = 24'h0020ff;
    done[2] = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(mk(2, 24'h0020ff, 10'h1ff));
    tick();
    chk("t4_full_same", 64'(fifo_full[2]), 64'd1);
    chk("t4_no_ovf", 64'(overflow[2]), 64'd0);
    chk("t4_no_drop", 64'(drop_count), 64'd0);
    done[2] = 1'b0;
    wait_drain("t4_drain");
    chk("t4_full_after", 64'(fifo_full[2]), 64'd0);

    // T5: masked channel ignored; done held high across reset gives one push
    do_reset();
    out_ready = 1'b1;
    channel_mask[9] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      pulse(9, AB'(10'h090 + p), TW'(24'h003000 + p), 1'b0);
      chk("t5_masked", 64'(out_valid), 64'd0);
    end
    channel_mask[9] = 1'b0;
    dout[9*AB +: AB] = 10'h099;
    timestamp = 24'h003100;
    done[9] = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    exp_q.push_back(mk(9, 24'h003100, 10'h099));
    reset = 1'b0;
    repeat (6) tick();
    done[9] = 1'b0;
    wait_drain("t5_drain");

    // T6: forced drops saturate the 2-bit counter
    do_reset();
    out_ready = 1'b0;
    for (int p = 0; p < 5; p++) pulse(1, AB'(10'h010 + p), TW'(24'h004000 + p), 1'b1);
    for (int n = 1; n <= 5; n++) begin
      pulse(1, AB'(10'h020 + n), TW'(24'h004100 + n), 1'b0);
      chk("t6_drop", 64'(drop_count), (n < 3) ? 64'(n) : 64'd3);
    end
    chk("t6_ovf", 64'(overflow), 64'd1 << 1);
    clear_pulse();
    chk("t6_clr_drop", 64'(drop_count), 64'd0);
    out_ready = 1'b1;
    wait_drain("t6_drain");
    chk("end_idle", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
